// File: rtl/cpu_mc_core_if.sv
// Instruction/data memory request-acknowledge bundle for cpu_mc_core.
// master = core side, slave = memory side; requests hold until the matching ack.
interface cpu_mc_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_ack;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/cpu_mc_core.sv
// Multi-cycle 16-bit-instruction load/store core, 4-entry RF; CPU_MC_PERF_EN adds cycle/retire counters.
// Latency (zero-wait): ALU/LDI 3, LD 4, ST 3, BEQZ 2 cycles; HLT parks the core.
// Backpressure: FETCH and MEM stall with request and address held until the memory acks.
module cpu_mc_core #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    cpu_mc_core_if.master     bus,
    output logic              hlt,
    output logic [ADDR_W-1:0] pc
`ifdef CPU_MC_PERF_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LDI  = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_BEQZ = 3'd6;
    localparam logic [2:0] OP_HLT  = 3'd7;

    state_t            state, state_nxt;
    logic [15:0]       ir;
    logic [DATA_W-1:0] rf [4];
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] ea_q;

    logic [2:0]        op;
    logic [1:0]        rd_a, rs_a, rt_a;
    logic [DATA_W-1:0] rs_val, rt_val, st_val;
    logic [DATA_W-1:0] imm_d;
    logic [ADDR_W-1:0] imm_a;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] ea_c;
    logic [DATA_W-1:0] alu_c;
    logic              br_taken;

    // Instruction field decode; ST reuses the rd slot as its data source.
    always_comb begin
        op       = ir[15:13];
        rd_a     = ir[12:11];
        rs_a     = ir[10:9];
        rt_a     = ir[8:7];
        rs_val   = rf[rs_a];
        rt_val   = rf[rt_a];
        st_val   = rf[rd_a];
        imm_d    = DATA_W'($signed(ir[8:0]));
        imm_a    = ADDR_W'($signed(ir[8:0]));
        base_a   = ADDR_W'(rs_val);
        pc_inc   = pc + ADDR_W'(1);
        br_tgt   = pc_inc + imm_a;
        ea_c     = base_a + imm_a;
        br_taken = (rs_val == '0);
    end

    always_comb begin
        alu_c = '0;
        case (op)
            OP_ADD:  alu_c = rs_val + rt_val;
            OP_SUB:  alu_c = rs_val - rt_val;
            OP_NAND: alu_c = ~(rs_val & rt_val);
            OP_LDI:  alu_c = imm_d;
            default: alu_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (bus.imem_ack) state_nxt = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_NAND, OP_LDI: state_nxt = S_WB;
                    OP_LD, OP_ST:                    state_nxt = S_MEM;
                    OP_BEQZ:                         state_nxt = S_FETCH;
                    default:                         state_nxt = S_HALT;
                endcase
            end
            S_MEM:   if (bus.dmem_ack) state_nxt = (op == OP_LD) ? S_WB : S_FETCH;
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Strobes come straight from state; data-side buses read as zero outside MEM.
    always_comb begin
        bus.imem_req   = (state == S_FETCH);
        bus.imem_addr  = pc;
        bus.dmem_req   = (state == S_MEM);
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        hlt            = (state == S_HALT);
        if (state == S_MEM) begin
            bus.dmem_addr = ea_q;
            if (op == OP_ST) begin
                bus.dmem_we    = 1'b1;
                bus.dmem_wdata = wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= '0;
            result_q <= '0;
            wdata_q  <= '0;
            ea_q     <= '0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (bus.imem_ack) ir <= bus.imem_rdata;
                S_EXEC: begin
                    result_q <= alu_c;
                    ea_q     <= ea_c;
                    wdata_q  <= st_val;
                    if (op == OP_BEQZ) pc <= br_taken ? br_tgt : pc_inc;
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        if (op == OP_LD) result_q <= bus.dmem_rdata;
                        else             pc       <= pc_inc;
                    end
                end
                S_WB: begin
                    rf[rd_a] <= result_q;
                    pc       <= pc_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_MC_PERF_EN
    logic ret_evt;

    // An instruction retires when it leaves the core for good: WB, ST ack, BEQZ/HLT in EXEC.
    always_comb begin
        ret_evt = 1'b0;
        case (state)
            S_WB:    ret_evt = 1'b1;
            S_MEM:   ret_evt = bus.dmem_ack && (op == OP_ST);
            S_EXEC:  ret_evt = (op == OP_BEQZ) || (op == OP_HLT);
            default: ret_evt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
            if (ret_evt)         ret_cnt <= ret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mc_core.sv
// Bench for cpu_mc_core: memory models with programmable waits, store scoreboard plus directed timing checks.
module tb_cpu_mc_core;
    localparam int DW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_mc_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    logic          hlt;
    logic [AW-1:0] pc;
`ifdef CPU_MC_PERF_EN
    logic [31:0]   cyc_cnt, ret_cnt;
`endif

    cpu_mc_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(8'h00)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .hlt(hlt),
        .pc(pc)
`ifdef CPU_MC_PERF_EN
        ,
        .cyc_cnt(cyc_cnt),
        .ret_cnt(ret_cnt)
`endif
    );

    logic [15:0]   imem [256];
    logic [DW-1:0] dmem [256];
    logic          imem_en   = 1'b1;
    logic          ack_en    = 1'b1;
    logic          force_ack = 1'b0;
    int            dmem_wait = 0;
    int            wait_cnt  = 0;

    assign bus.imem_ack   = bus.imem_req && imem_en;
    assign bus.imem_rdata = imem[bus.imem_addr];
    assign bus.dmem_ack   = force_ack || (ack_en && bus.dmem_req && (wait_cnt == dmem_wait));
    assign bus.dmem_rdata = dmem[bus.dmem_addr];

    always @(posedge clk) begin
        if (bus.dmem_req && !bus.dmem_ack) wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
        if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    end

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } st_t;
    st_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every completed store is matched against the next expected one.
    always @(negedge clk) begin
        st_t e;
        if (!rst && bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL store_unexpected: got addr 0x%0h data 0x%0h, expected no store",
                         bus.dmem_addr, bus.dmem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("store_addr", 32'(bus.dmem_addr), 32'(e.addr));
                check("store_data", 32'(bus.dmem_wdata), 32'(e.data));
            end
        end
    end

    function automatic logic [15:0] ri(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt);
        return {op, rd, rs, rt, 7'b0};
    endfunction

    function automatic logic [15:0] ii(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [8:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hE000;
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_hlt(output int cyc);
        cyc = 0;
        while (!hlt && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hlt_reached", 32'(hlt), 32'd1);
    endtask

    task automatic wait_fetch_at(input logic [AW-1:0] addr, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (bus.imem_req && pc == addr) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic push_st(input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        int cyc, n, bad;
        logic ack_seen, got;

        // Basic program: timing to halt and reset state.
        clear_mem();
        imem[0] = ii(3'd3, 2'd1, 2'd0, 9'd5);
        imem[1] = ii(3'd3, 2'd2, 2'd0, 9'd3);
        imem[2] = ri(3'd0, 2'd3, 2'd1, 2'd2);
        imem[3] = 16'hE000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_hlt", 32'(hlt), 32'd0);
        check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        check("rst_imem_req", 32'(bus.imem_req), 32'd1);
        rst = 1'b0;
        run_to_hlt(cyc);
        check("hlt_cycle", 32'(cyc), 32'd11);
        check("hlt_pc", 32'(pc), 32'd3);
        check("halt_no_imem_req", 32'(bus.imem_req), 32'd0);
`ifdef CPU_MC_PERF_EN
        check("ret_cnt", ret_cnt, 32'd4);
        check("cyc_cnt", cyc_cnt, 32'd11);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("halt_pc_stable", 32'(pc), 32'd3);
        check("halt_stays", 32'(hlt), 32'd1);
`ifdef CPU_MC_PERF_EN
        check("ret_cnt_frozen", ret_cnt, 32'd4);
        check("cyc_cnt_frozen", cyc_cnt, 32'd11);
`endif

        // ALU results made visible through stores.
        clear_mem();
        imem[0]  = ii(3'd3, 2'd1, 2'd0, 9'd5);
        imem[1]  = ii(3'd3, 2'd2, 2'd0, 9'd3);
        imem[2]  = ri(3'd0, 2'd3, 2'd1, 2'd2);
        imem[3]  = ii(3'd5, 2'd3, 2'd0, 9'd0);
        imem[4]  = ri(3'd1, 2'd3, 2'd2, 2'd1);
        imem[5]  = ii(3'd5, 2'd3, 2'd0, 9'd1);
        imem[6]  = ii(3'd3, 2'd1, 2'd0, 9'h1FF);
        imem[7]  = ii(3'd3, 2'd2, 2'd0, 9'h00F);
        imem[8]  = ri(3'd2, 2'd3, 2'd1, 2'd2);
        imem[9]  = ii(3'd5, 2'd3, 2'd0, 9'd2);
        imem[10] = 16'hE000;
        push_st(8'd0, 8'h08);
        push_st(8'd1, 8'hFE);
        push_st(8'd2, 8'hF0);
        do_reset();
        run_to_hlt(cyc);
        check("alu_queue_drained", 32'(exp_q.size()), 32'd0);
        check("alu_pc", 32'(pc), 32'd10);

        // Store then load with three wait states on the data port.
        clear_mem();
        dmem_wait = 3;
        imem[0] = ii(3'd3, 2'd1, 2'd0, 9'h05A);
        imem[1] = ii(3'd5, 2'd1, 2'd0, 9'd4);
        imem[2] = ii(3'd4, 2'd2, 2'd0, 9'd4);
        imem[3] = ii(3'd5, 2'd2, 2'd0, 9'd5);
        imem[4] = 16'hE000;
        push_st(8'd4, 8'h5A);
        push_st(8'd5, 8'h5A);
        do_reset();
        for (int i = 0; i < 50 && !bus.dmem_req; i++) @(negedge clk);
        check("st_req_seen", 32'(bus.dmem_req), 32'd1);
        n = 0;
        bad = 0;
        ack_seen = 1'b0;
        while (!ack_seen && n < 20) begin
            n++;
            if (!bus.dmem_req || !bus.dmem_we || bus.dmem_addr != 8'd4 || bus.dmem_wdata != 8'h5A) bad++;
            ack_seen = bus.dmem_ack;
            @(negedge clk);
        end
        check("st_hold_cycles", 32'(n), 32'd4);
        check("st_hold_stable", 32'(bad), 32'd0);
        run_to_hlt(cyc);
        check("ldst_queue_drained", 32'(exp_q.size()), 32'd0);
        dmem_wait = 0;

        // Taken BEQZ back to itself.
        clear_mem();
        imem[0]     = ii(3'd6, 2'd0, 2'd0, 9'd15);
        imem[8'h10] = ii(3'd6, 2'd0, 2'd0, 9'h1FF);
        do_reset();
        wait_fetch_at(8'h10, "beqz_reach_10");
        repeat (2) @(negedge clk);
        check("beqz_loop_pc", 32'(pc), 32'h10);
        check("beqz_loop_fetch", 32'(bus.imem_req), 32'd1);
        repeat (2) @(negedge clk);
        check("beqz_loop_pc2", 32'(pc), 32'h10);

        // Not-taken BEQZ falls through.
        clear_mem();
        imem[0]     = ii(3'd3, 2'd0, 2'd0, 9'd1);
        imem[1]     = ii(3'd6, 2'd0, 2'd1, 9'd14);
        imem[8'h10] = ii(3'd6, 2'd0, 2'd0, 9'h1FF);
        imem[8'h11] = 16'hE000;
        do_reset();
        run_to_hlt(cyc);
        check("beqz_fall_pc", 32'(pc), 32'h11);

        // Backward branch wraps below zero; fall-through at 0xFF wraps to 0.
        clear_mem();
        imem[0]     = ii(3'd3, 2'd0, 2'd0, 9'd1);
        imem[1]     = ii(3'd6, 2'd0, 2'd1, 9'h1FD);
        imem[8'hFF] = ii(3'd6, 2'd0, 2'd0, 9'd0);
        do_reset();
        wait_fetch_at(8'hFF, "beqz_wrap_target");
        repeat (2) @(negedge clk);
        check("pc_wrap_zero", 32'(pc), 32'h0);
        check("pc_wrap_fetch", 32'(bus.imem_req), 32'd1);

        // Reset while a store waits for its ack; a stray late ack changes nothing.
        clear_mem();
        imem[0] = ii(3'd5, 2'd0, 2'd0, 9'd7);
        imem[1] = 16'hE000;
        ack_en  = 1'b0;
        do_reset();
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.dmem_req;
        end
        check("mem_pending", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem_req_drop", 32'(bus.dmem_req), 32'd0);
        check("rst_mem_we_drop", 32'(bus.dmem_we), 32'd0);
        check("rst_mem_pc", 32'(pc), 32'h0);
        check("rst_mem_imem_req", 32'(bus.imem_req), 32'd1);
        imem_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        check("late_ack_no_req", 32'(bus.dmem_req), 32'd0);
        check("late_ack_fetch", 32'(bus.imem_req), 32'd1);
        check("late_ack_pc", 32'(pc), 32'h0);
        imem_en = 1'b1;
        ack_en  = 1'b1;
        push_st(8'd7, 8'h00);
        run_to_hlt(cyc);
        check("rst_mem_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rst_mem_final_pc", 32'(pc), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
